arm_fetch: RTL and testbench
============================

// Module: arm_fetch
// PURPOSE
//  Instruction fetch sequencer on the producer side of the control decoder. Owns the PC and
//  fetches each word from instruction memory over a req/ack handshake. Presents it as inst/inst_valid
//  to the decoder and datapath, then applies the decoder's pc_we/pc_in_sel/halted outcome
//  once execute signals completion.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PC value loaded on reset (text segment base)
//  MAX_WAIT  255            max cycles imem_req may wait for imem_ack before fault
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_b        in   1   asynchronous reset, active low
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  byte address of fetch (= pc), bits[1:0] always 0
//  imem_ack     in   1   memory returns imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  inst         out  32  latched instruction to decoder
//  inst_valid   out  1   inst is stable and may be executed
//  pc           out  32  address of inst
//  pc_plus4     out  32  pc + 4 (mod 2^32), for link register writes
//  exec_done    in   1   execute has consumed inst; decoder outputs valid this cycle
//  pc_we        in   1   decoder: update PC
//  pc_in_sel    in   2   decoder: 0 branch_addr, 1 pc+4, 2 hold pc, 3 treated as 1
//  branch_addr  in   32  branch target; bits[1:0] forced to 0 on load
//  halted       in   1   decoder: halt instruction executing
//  fetch_halted out  1   sticky: core halted
//  fetch_fault  out  1   sticky: imem_ack timeout
// BEHAVIOUR
//  Reset (async, rst_b=0): state=FETCH, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0,
//   fetch_halted=0, fetch_fault=0, wait_cnt=0. imem_req drops immediately on reset assertion.
//  imem_req is a registered state decode. It rises the first clock after rst_b deasserts.
//  States: FETCH, ISSUE, HALT, FAULT.
//  FETCH: imem_req=1, imem_addr=pc, inst_valid=0. Address is stable while req is high.
//   imem_ack=1: inst<=imem_rdata, wait_cnt<=0, go to ISSUE (inst_valid=1 next cycle).
//   No ack: wait_cnt++. If wait_cnt==MAX_WAIT with no ack, go to FAULT.
//  ISSUE: inst_valid=1, imem_req=0, inst/pc held. exec_done=0: stay in ISSUE.
//   exec_done=1, priority order:
//    1. halted=1: go to HALT, pc unchanged (halted beats pc_we).
//    2. pc_we=1: pc<=per pc_in_sel (2 holds pc), go to FETCH.
//    3. pc_we=0: pc unchanged, go to FETCH (same address refetched).
//  HALT: terminal until reset. fetch_halted=1, inst_valid=0, imem_req=0. Ignores all inputs.
//  FAULT: terminal until reset. fetch_fault=1, inst_valid=0, imem_req=0. Late ack is ignored.
//  Latency: ack in cycle N -> inst_valid in N+1. exec_done in cycle M -> imem_req with new pc in M+1.
//   Minimum is 2 cycles per instruction (ack in the first FETCH cycle, exec_done in the first ISSUE cycle).
//  Arithmetic: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. pc_plus4 is combinational from pc.
//  exec_done outside ISSUE is ignored. imem_ack outside FETCH is ignored.
// TESTING
//  Reset release: first imem_req with imem_addr=0x0040_0000; inst_valid=0 until ack; inst=0 before.
//  Ack after 3 cycles, rdata=0xE280_1001: req/addr stable 3 cycles; inst_valid 1 cycle after ack;
//   exec_done with pc_we=1,sel=1 -> next req addr=0x0040_0004.
//  Branch: pc_we=1, sel=0, branch_addr=0x0040_0103 -> next fetch addr=0x0040_0100.
//  pc_we=0 (or sel=2) on exec_done -> refetch same address.
//  halted=1 together with pc_we=1 -> fetch_halted=1, pc unchanged; no further req despite later acks.
//  MAX_WAIT=4, no ack -> fetch_fault=1 after 4 wait cycles, req drops. Separately, pc=0xFFFF_FFFC,
//   sel=1 -> next addr 0x0; assert rst_b=0 mid-FETCH -> req low at once, pc=RESET_PC.

Source files
------------

// File: rtl/arm_fetch.sv
// arm_fetch: PC owner and imem req/ack fetch sequencer that issues one instruction at a time to execute
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        pc_we,
  input  logic [1:0]  pc_in_sel,
  input  logic [31:0] branch_addr,
  input  logic        halted,
  output logic        fetch_halted,
  output logic        fetch_fault
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {FETCH, ISSUE, HALT, FAULT} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic [31:0] pc_nx;
  logic fetching;
  // the cycle after reset release sits in FETCH with req still low; it must not count or accept acks
  assign fetching = state == FETCH && imem_req;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (fetching)
      state_nx = imem_ack ? ISSUE : (wait_cnt == WW'(MAX_WAIT - 1)) ? FAULT : FETCH;
    else if (state == ISSUE && exec_done) begin
      state_nx = halted ? HALT : FETCH;
      if (!halted && pc_we)
        pc_nx = pc_in_sel == 2'd0 ? (branch_addr & ~32'h3) : pc_in_sel == 2'd2 ? pc : pc_plus4;
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      inst         <= '0;
      inst_valid   <= 1'b0;
      imem_req     <= 1'b0;
      fetch_halted <= 1'b0;
      fetch_fault  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      imem_req     <= state_nx == FETCH;
      inst_valid   <= state_nx == ISSUE;
      fetch_halted <= state_nx == HALT;
      fetch_fault  <= state_nx == FAULT;
      if (fetching) begin
        wait_cnt <= imem_ack ? '0 : wait_cnt + 1'b1;
        if (imem_ack) inst <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: directed fetch/execute sequences; a monitor checks each new request and issued instruction against queued expectations
module tb_arm_fetch;
  logic clk = 0, rst_b = 1, imem_ack = 0, exec_done = 0, pc_we = 0, halted = 0;
  logic [31:0] imem_rdata = 0, branch_addr = 0;
  logic [1:0] pc_in_sel = 0;
  logic imem_req, inst_valid, fetch_halted, fetch_fault;
  logic [31:0] imem_addr, inst, pc, pc_plus4;

  arm_fetch #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_b(rst_b), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done), .pc_we(pc_we),
    .pc_in_sel(pc_in_sel), .branch_addr(branch_addr), .halted(halted),
    .fetch_halted(fetch_halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [31:0] fetch_q[$];
  logic [95:0] issue_q[$];
  logic [95:0] exp_issue;
  logic req_q = 0, val_q = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // scoreboard monitor: every rising req and rising inst_valid must match the next queued expectation
  always @(negedge clk) begin
    if (imem_req && !req_q) begin
      if (fetch_q.size() == 0) fail("unexpected_req");
      else chk("fetch_addr", imem_addr, fetch_q.pop_front());
    end
    if (inst_valid && !val_q) begin
      if (issue_q.size() == 0) fail("unexpected_inst_valid");
      else begin
        exp_issue = issue_q.pop_front();
        chk("issue_inst", inst, exp_issue[95:64]);
        chk("issue_pc", pc, exp_issue[63:32]);
        chk("issue_pc_plus4", pc_plus4, exp_issue[31:0]);
      end
    end
    req_q <= imem_req;
    val_q <= inst_valid;
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    if (!imem_req) fail("req_timeout");
  endtask

  task automatic do_fetch(input logic [31:0] data, input logic [31:0] a, input logic [31:0] p4, input int dly);
    issue_q.push_back({data, a, p4});
    wait_req();
    repeat (dly) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, a);
      chk("no_valid_in_fetch", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    imem_ack = 1; imem_rdata = data;
    @(negedge clk);
    imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic do_exec(input logic we, input logic [1:0] sel, input logic [31:0] ba, input logic h, input logic [31:0] nxt);
    int n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    if (!inst_valid) fail("valid_timeout");
    chk("req_low_in_issue", 32'(imem_req), 32'd0);
    if (!h) fetch_q.push_back(nxt);
    exec_done = 1; pc_we = we; pc_in_sel = sel; branch_addr = ba; halted = h;
    @(negedge clk);
    exec_done = 0; pc_we = 0; pc_in_sel = 0; branch_addr = 0; halted = 0;
  endtask

  initial begin
    int n;
    #1 rst_b = 0;
    fetch_q.push_back(32'h0040_0000);
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_flags", {30'd0, fetch_halted, fetch_fault}, 32'd0);
    rst_b = 1;
    // ack on the 4th request cycle is the last one allowed before the timeout
    do_fetch(32'hE280_1001, 32'h0040_0000, 32'h0040_0004, 3);
    do_exec(1, 2'd1, 32'h0, 0, 32'h0040_0004);
    do_fetch(32'h1111_1111, 32'h0040_0004, 32'h0040_0008, 0);
    do_exec(1, 2'd0, 32'h0040_0103, 0, 32'h0040_0100);
    do_fetch(32'h2222_2222, 32'h0040_0100, 32'h0040_0104, 0);
    do_exec(0, 2'd1, 32'h0, 0, 32'h0040_0100);
    do_fetch(32'h3333_3333, 32'h0040_0100, 32'h0040_0104, 1);
    do_exec(1, 2'd2, 32'h0, 0, 32'h0040_0100);
    do_fetch(32'h4444_4444, 32'h0040_0100, 32'h0040_0104, 0);
    do_exec(1, 2'd3, 32'h0, 0, 32'h0040_0104);
    do_fetch(32'h5555_5555, 32'h0040_0104, 32'h0040_0108, 0);
    do_exec(1, 2'd0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC);
    do_fetch(32'h6666_6666, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    do_exec(1, 2'd1, 32'h0, 0, 32'h0000_0000);
    chk("wrap_req", 32'(imem_req), 32'd1);
    rst_b = 0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0040_0000);
    chk("midrst_inst", inst, 32'h0);
    @(negedge clk);
    fetch_q.push_back(32'h0040_0000);
    rst_b = 1;
    do_fetch(32'h7777_7777, 32'h0040_0000, 32'h0040_0004, 0);
    do_exec(1, 2'd0, 32'h0000_1000, 1, 32'h0);
    chk("halt_flag", 32'(fetch_halted), 32'd1);
    chk("halt_pc", pc, 32'h0040_0000);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    imem_ack = 1; exec_done = 1; pc_we = 1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 0; exec_done = 0; pc_we = 0;
    chk("halt_sticky", 32'(fetch_halted), 32'd1);
    rst_b = 0;
    @(negedge clk);
    chk("rst_clears_halt", 32'(fetch_halted), 32'd0);
    fetch_q.push_back(32'h0040_0000);
    rst_b = 1;
    wait_req();
    n = 0;
    while (imem_req && n < 20) begin n++; @(negedge clk); end
    chk("fault_wait_cycles", 32'(n), 32'd4);
    chk("fault_flag", 32'(fetch_fault), 32'd1);
    chk("fault_req", 32'(imem_req), 32'd0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_ack = 0;
    chk("fault_late_ack_valid", 32'(inst_valid), 32'd0);
    chk("fault_late_ack_inst", inst, 32'h0);
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
    chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
